// File: rtl/prng_ranged_multichannel.sv
// prng_ranged_multichannel: per-channel 32-bit LFSR random source with
// two-stage [lower, upper] range scaling and runtime reseed.
module prng_ranged_multichannel #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned OUT_W        = 16,
    parameter logic [31:0] DEFAULT_SEED = 32'hACE12468
) (
    input  logic                      iClock,
    input  logic                      iReset,
    input  logic [31:0]               iSeed,
    input  logic                      iReseed,
    input  logic [CHANNELS-1:0]       iReq,
    input  logic [CHANNELS*OUT_W-1:0] iLower,
    input  logic [CHANNELS*OUT_W-1:0] iUpper,
    output logic [CHANNELS-1:0]       oValid,
    output logic [CHANNELS*OUT_W-1:0] oValue,
    output logic [CHANNELS-1:0]       oRangeErr
);

    localparam int unsigned PW = 2 * OUT_W + 1;

    // Stage-1 bundle: everything stage 2 needs, frozen at request time
    typedef struct packed {
        logic             valid;
        logic             err;
        logic [OUT_W-1:0] sample;
        logic [OUT_W-1:0] lower;
        logic [OUT_W:0]   range;
    } s1_t;

    // Golden-ratio spread keeps channel seeds apart; zero would lock the LFSR
    function automatic logic [31:0] chan_seed(
        input logic [31:0] base,
        input int unsigned c
    );
        logic [31:0] mix;
        mix = base ^ (32'(c) * 32'h9E3779B9);
        return (mix == 32'd0) ? DEFAULT_SEED : mix;
    endfunction

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [31:0]      lfsr;
        logic             fb;
        logic             take;
        logic [OUT_W-1:0] lower;
        logic [OUT_W-1:0] upper;
        logic [OUT_W:0]   range;
        logic [PW-1:0]    prod;
        logic [OUT_W-1:0] scaled;
        s1_t              s1;
        logic             valid_q;
        logic             err_q;
        logic [OUT_W-1:0] value_q;

        assign lower = iLower[c*OUT_W +: OUT_W];
        assign upper = iUpper[c*OUT_W +: OUT_W];

        // Taps 32,31,30,10; reseed on the same edge swallows the request
        assign fb   = lfsr[31] ^ lfsr[30] ^ lfsr[29] ^ lfsr[9];
        assign take = iReq[c] & ~iReseed;

        // Range is one bit wider so a full-scale span is 2^OUT_W
        assign range = {1'b0, upper} - {1'b0, lower} + (OUT_W+1)'(1);

        // Product >> OUT_W never exceeds upper - lower, so it fits OUT_W bits
        assign prod   = PW'(s1.sample) * PW'(s1.range);
        assign scaled = OUT_W'(prod >> OUT_W);

        // Generator state: load seed on reset/reseed, shift only on a draw
        always_ff @(posedge iClock or posedge iReset) begin
            if (iReset) begin
                lfsr <= chan_seed(iSeed, c);
            end else if (iReseed) begin
                lfsr <= chan_seed(iSeed, c);
            end else if (iReq[c]) begin
                lfsr <= {lfsr[30:0], fb};
            end
        end

        // Stage 1: capture pre-shift sample and bounds of the accepted draw
        always_ff @(posedge iClock or posedge iReset) begin
            if (iReset) begin
                s1 <= '0;
            end else begin
                s1.valid <= take;
                if (take) begin
                    s1.err    <= lower > upper;
                    s1.sample <= lfsr[31 -: OUT_W];
                    s1.lower  <= lower;
                    s1.range  <= range;
                end
            end
        end

        // Stage 2: scale into range; inverted range returns the lower bound
        always_ff @(posedge iClock or posedge iReset) begin
            if (iReset) begin
                valid_q <= 1'b0;
                err_q   <= 1'b0;
                value_q <= '0;
            end else begin
                valid_q <= s1.valid;
                err_q   <= s1.valid & s1.err;
                if (s1.valid) begin
                    value_q <= s1.err ? s1.lower : s1.lower + scaled;
                end
            end
        end

        assign oValid[c]                   = valid_q;
        assign oRangeErr[c]                = err_q;
        assign oValue[c*OUT_W +: OUT_W]    = value_q;
    end

endmodule

// File: tb/tb_prng_ranged_multichannel.sv
// tb_prng_ranged_multichannel: directed checks of draw latency, LFSR
// sequence, range scaling, inverted ranges, zero seed, reseed and reset.
module tb_prng_ranged_multichannel;

    localparam int CH = 4;
    localparam int W  = 16;

    logic              iClock = 1'b0;
    logic              iReset;
    logic [31:0]       iSeed;
    logic              iReseed;
    logic [CH-1:0]     iReq;
    logic [CH*W-1:0]   iLower;
    logic [CH*W-1:0]   iUpper;
    logic [CH-1:0]     oValid;
    logic [CH*W-1:0]   oValue;
    logic [CH-1:0]     oRangeErr;

    int total = 0;
    int bad   = 0;

    prng_ranged_multichannel #(
        .CHANNELS(CH),
        .OUT_W(W),
        .DEFAULT_SEED(32'hACE12468)
    ) dut (
        .iClock(iClock),
        .iReset(iReset),
        .iSeed(iSeed),
        .iReseed(iReseed),
        .iReq(iReq),
        .iLower(iLower),
        .iUpper(iUpper),
        .oValid(oValid),
        .oValue(oValue),
        .oRangeErr(oRangeErr)
    );

    always #5 iClock = ~iClock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int c, input logic [W-1:0] lo,
                          input logic [W-1:0] hi);
        iLower[c*W +: W] = lo;
        iUpper[c*W +: W] = hi;
    endtask

    task automatic set_all(input logic [W-1:0] lo, input logic [W-1:0] hi);
        for (int c = 0; c < CH; c++) set_ch(c, lo, hi);
    endtask

    task automatic do_reset();
        iReset = 1'b1;
        @(negedge iClock);
        iReset = 1'b0;
    endtask

    function automatic logic [W-1:0] val(input int c);
        return oValue[c*W +: W];
    endfunction

    logic [W-1:0] t2_exp [5];
    logic [W-1:0] lo_r [CH];
    logic [W-1:0] hi_r [CH];

    initial begin
        t2_exp[0] = 16'hACE1;
        t2_exp[1] = 16'h59C2;
        t2_exp[2] = 16'hB384;
        t2_exp[3] = 16'h6709;
        t2_exp[4] = 16'hCE12;

        iReset  = 1'b1;
        iSeed   = 32'hACE12468;
        iReseed = 1'b0;
        iReq    = '0;
        set_all(16'd0, 16'd0);
        repeat (2) @(negedge iClock);
        chk("rst_valid", 32'(oValid), 32'h0);
        chk("rst_value", oValue[31:0], 32'h0);
        chk("rst_value_hi", oValue[63:32], 32'h0);
        chk("rst_err", 32'(oRangeErr), 32'h0);
        iReset = 1'b0;

        // T1: single draw in [0,99]; bounds changed after stage 1
        set_ch(0, 16'd0, 16'd99);
        iReq = 4'b0001;
        @(negedge iClock);
        chk("t1_no_early_valid", 32'(oValid), 32'h0);
        iReq = '0;
        set_ch(0, 16'd200, 16'd300);
        @(negedge iClock);
        chk("t1_valid", 32'(oValid), 32'h1);
        chk("t1_value", 32'(val(0)), 32'd67);
        chk("t1_err", 32'(oRangeErr), 32'h0);
        @(negedge iClock);
        chk("t1_pulse_drop", 32'(oValid), 32'h0);
        chk("t1_value_hold", 32'(val(0)), 32'd67);

        // T2: full-scale back-to-back draws follow the LFSR sequence
        do_reset();
        set_ch(0, 16'd0, 16'hFFFF);
        iReq = 4'b0001;
        @(negedge iClock);
        for (int i = 0; i < 5; i++) begin
            @(negedge iClock);
            chk($sformatf("t2_valid%0d", i), 32'(oValid), 32'h1);
            chk($sformatf("t2_value%0d", i), 32'(val(0)), 32'(t2_exp[i]));
            if (i == 3) iReq = '0;
        end
        @(negedge iClock);
        chk("t2_end_valid", 32'(oValid), 32'h0);

        // T3: degenerate range on every channel, then inverted range
        set_all(16'd10, 16'd10);
        iReq = 4'hF;
        @(negedge iClock);
        for (int n = 0; n < 40; n++) begin
            @(negedge iClock);
            chk("t3_valid", 32'(oValid), 32'hF);
            for (int c = 0; c < CH; c++)
                chk($sformatf("t3_deg_ch%0d", c), 32'(val(c)), 32'd10);
        end
        set_all(16'd50, 16'd20);
        @(negedge iClock);
        iReq = '0;
        @(negedge iClock);
        chk("t3_inv_valid", 32'(oValid), 32'hF);
        chk("t3_inv_err", 32'(oRangeErr), 32'hF);
        for (int c = 0; c < CH; c++)
            chk($sformatf("t3_inv_ch%0d", c), 32'(val(c)), 32'd50);

        // T4: zero base seed falls back to the default on channel 0
        iSeed = 32'h0;
        do_reset();
        set_ch(0, 16'd0, 16'd99);
        for (int c = 1; c < CH; c++) set_ch(c, 16'd0, 16'hFFFF);
        iReq = 4'hF;
        @(negedge iClock);
        iReq = '0;
        @(negedge iClock);
        chk("t4_err", 32'(oRangeErr), 32'h0);
        chk("t4_ch0", 32'(val(0)), 32'd67);
        chk("t4_ch1", 32'(val(1)), 32'h9E37);
        chk("t4_ch2", 32'(val(2)), 32'h3C6E);
        chk("t4_ch3", 32'(val(3)), 32'hDAA6);

        // T5: reseed with two draws in flight and a same-edge request
        iSeed = 32'hACE12468;
        do_reset();
        set_ch(1, 16'd0, 16'hFFFF);
        iReq = 4'b0010;
        @(negedge iClock);
        @(negedge iClock);
        chk("t5_first_valid", 32'(oValid), 32'h2);
        chk("t5_first_value", 32'(val(1)), 32'h32D6);
        iReseed = 1'b1;
        @(negedge iClock);
        chk("t5_inflight_valid", 32'(oValid), 32'h2);
        chk("t5_inflight_value", 32'(val(1)), 32'h65AC);
        iReseed = 1'b0;
        iReq = '0;
        @(negedge iClock);
        chk("t5_dropped_req", 32'(oValid), 32'h0);
        iReq = 4'b0010;
        @(negedge iClock);
        iReq = '0;
        @(negedge iClock);
        chk("t5_replay_valid", 32'(oValid), 32'h2);
        chk("t5_replay_value", 32'(val(1)), 32'h32D6);

        // T6: asynchronous reset with both stages occupied
        set_all(16'd0, 16'hFFFF);
        iReq = 4'hF;
        @(negedge iClock);
        @(negedge iClock);
        #2 iReset = 1'b1;
        #1;
        chk("t6_async_valid", 32'(oValid), 32'h0);
        chk("t6_async_value_lo", oValue[31:0], 32'h0);
        chk("t6_async_value_hi", oValue[63:32], 32'h0);
        @(negedge iClock);
        iReset = 1'b0;
        iReq = '0;
        @(negedge iClock);
        chk("t6_idle1", 32'(oValid), 32'h0);
        @(negedge iClock);
        chk("t6_idle2", 32'(oValid), 32'h0);

        // Random ordered bounds: every result must stay inside them
        for (int it = 0; it < 30; it++) begin
            for (int c = 0; c < CH; c++) begin
                lo_r[c] = W'($urandom_range(0, 65535));
                hi_r[c] = W'($urandom_range(32'(lo_r[c]), 65535));
                set_ch(c, lo_r[c], hi_r[c]);
            end
            iReq = 4'hF;
            @(negedge iClock);
            for (int k = 0; k < 2; k++) begin
                @(negedge iClock);
                iReq = '0;
                chk("sweep_valid", 32'(oValid), 32'hF);
                chk("sweep_err", 32'(oRangeErr), 32'h0);
                for (int c = 0; c < CH; c++)
                    chk($sformatf("sweep_in_range_ch%0d", c),
                        32'(val(c) >= lo_r[c] && val(c) <= hi_r[c]), 32'h1);
            end
            @(negedge iClock);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
